// File: rtl/cto2_sweep_checker.sv
// cto2_sweep_checker
// Stimulus/response self-test for a CTO2 combinational cell. It walks the
// eight {a,b,c} vectors in order and holds each one long enough for the
// cell to settle. It samples s once per vector and builds the observed truth
// table. At the end it compares that table against EXPECTED and reports the
// result.
//
// Handshake: there is no valid/ready pair here. start is a request level
// that is acted on only in IDLE. done is a one-cycle completion strobe.
// busy is high for exactly the DRIVE/SAMPLE cycles of a sweep. abort cancels
// a running sweep and never produces done.
//
// Every output comes straight from a register or from decoded state, so no
// input reaches an output combinationally.
module cto2_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'h1A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       s,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] truth,
  output logic [3:0] err_cnt,
  output logic [2:0] first_fail,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Settle counter reload value: DRIVE lasts SETTLE_CYCLES cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] abc_q, abc_d;
  logic [7:0] truth_q, truth_d;
  logic [3:0] err_q, err_d;
  logic [2:0] ff_q, ff_d;
  logic       pass_q, pass_d;
  logic       mismatch;

  // Next-state and datapath logic for the sweep sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    abc_d    = abc_q;
    truth_d  = truth_q;
    err_d    = err_q;
    ff_d     = ff_q;
    pass_d   = pass_q;
    mismatch = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // start takes priority over abort here; abort means nothing in IDLE.
        if (start) begin
          truth_d = 8'h00;
          err_d   = 4'd0;
          ff_d    = 3'd0;
          pass_d  = 1'b0;
          idx_d   = 3'd0;
          abc_d   = 3'd0;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        if (abort) begin
          state_d = ST_IDLE;
          abc_d   = 3'd0;
          pass_d  = 1'b0;
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          // Partial truth/err/first_fail are left for inspection; this
          // vector's sample is dropped.
          state_d = ST_IDLE;
          abc_d   = 3'd0;
          pass_d  = 1'b0;
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
        end else begin
          truth_d[idx_q] = s;
          mismatch       = (s != EXPECTED[idx_q]);
          if (mismatch) begin
            err_d = err_q + 4'd1;
            // err_q still zero means this is the first failing vector.
            if (err_q == 4'd0) begin
              ff_d = idx_q;
            end
          end
          if (idx_q != 3'd7) begin
            idx_d   = idx_q + 3'd1;
            abc_d   = idx_q + 3'd1;
            cnt_d   = SETTLE_LOAD;
            state_d = ST_DRIVE;
          end else begin
            abc_d   = 3'd0;
            pass_d  = (err_d == 4'd0);
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        idx_d   = 3'd0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        abc_d   = 3'd0;
        idx_d   = 3'd0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and result registers; reset discards any partial sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      abc_q   <= 3'd0;
      truth_q <= 8'h00;
      err_q   <= 4'd0;
      ff_q    <= 3'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      truth_q <= truth_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    a          = abc_q[2];
    b          = abc_q[1];
    c          = abc_q[0];
    busy       = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    done       = (state_q == ST_DONE);
    pass       = pass_q;
    truth      = truth_q;
    err_cnt    = err_q;
    first_fail = ff_q;
    dbg_state  = state_q;
  end

endmodule
